// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin share of one spi_master among NREQ requesters; optional WAIT timeout via SPI_ARB_TIMEOUT_EN
module spi_arbiter #(
    parameter int NREQ     = 4,
    parameter int SS_SETUP = 2,
    parameter int SS_HOLD  = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_tdat,
    input  logic [2*NREQ-1:0] req_cdiv,
    input  logic [NREQ-1:0]   req_mlb,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rsp_rdata,
    output logic              err,
    output logic [NREQ-1:0]   ss_n,
    output logic              m_start,
    output logic [7:0]        m_tdat,
    output logic [1:0]        m_cdiv,
    output logic              m_mlb,
    input  logic              m_done,
    input  logic [7:0]        m_rdata
);
    localparam int W = $clog2(NREQ);
    localparam int CW = $clog2((SS_SETUP > SS_HOLD ? SS_SETUP : SS_HOLD) + 1);
    localparam logic [W:0] NR = (W+1)'(NREQ);

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    ptr_q, ptr_d, idx_q, idx_d, off, win;
    logic [W:0]      sum;
    logic [NREQ-1:0] rot, gnt_q, gnt_d;
    logic [7:0]      tdat_q, tdat_d, rdata_q, rdata_d;
    logic [1:0]      cdiv_q, cdiv_d;
    logic            mlb_q, mlb_d, done_q;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0]     to_q, to_d;
    logic            err_q, err_d;
`endif

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, then map back
    always_comb begin
        rot = NREQ'({req, req} >> ptr_q);
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) off = k[W-1:0];
        sum = {1'b0, ptr_q} + {1'b0, off};
        win = (sum >= NR) ? W'(sum - NR) : sum[W-1:0];
    end

    // Transfer sequencing: grant, ss setup, start strobe, wait for done, ss hold, acknowledge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        tdat_d  = tdat_q;
        cdiv_d  = cdiv_q;
        mlb_d   = mlb_q;
        rdata_d = rdata_q;
`ifdef SPI_ARB_TIMEOUT_EN
        to_d    = '0;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (|req) begin
                state_d = SETUP;
                idx_d   = win;
                gnt_d   = NREQ'(1) << win;
                tdat_d  = req_tdat[8*win +: 8];
                cdiv_d  = req_cdiv[2*win +: 2];
                mlb_d   = req_mlb[win];
                cnt_d   = CW'(SS_SETUP - 1);
            end
            SETUP: if (cnt_q == '0) state_d = START; else cnt_d = cnt_q - 1'b1;
            START: state_d = WAIT;
            WAIT: begin
`ifdef SPI_ARB_TIMEOUT_EN
                to_d = to_q + 16'd1;
`endif
                if (m_done && !done_q) begin
                    rdata_d = m_rdata;
                    cnt_d   = CW'(SS_HOLD - 1);
                    state_d = HOLD;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (to_q == 16'(TIMEOUT - 1)) begin
                    rdata_d = 8'hFF;
                    err_d   = 1'b1;
                    cnt_d   = CW'(SS_HOLD - 1);
                    state_d = HOLD;
`endif
                end
            end
            HOLD: if (cnt_q == '0) state_d = RESP; else cnt_d = cnt_q - 1'b1;
            RESP: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = (idx_q == W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            tdat_q  <= 8'hFF;
            cdiv_q  <= '0;
            mlb_q   <= 1'b0;
            rdata_q <= 8'hFF;
            done_q  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            tdat_q  <= tdat_d;
            cdiv_q  <= cdiv_d;
            mlb_q   <= mlb_d;
            rdata_q <= rdata_d;
            done_q  <= m_done;
`ifdef SPI_ARB_TIMEOUT_EN
            to_q    <= to_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign ack       = (state_q == RESP) ? gnt_q : '0;
    assign ss_n      = (state_q inside {SETUP, START, WAIT, HOLD}) ? ~gnt_q : '1;
    assign m_start   = (state_q == START);
    assign m_tdat    = tdat_q;
    assign m_cdiv    = cdiv_q;
    assign m_mlb     = mlb_q;
    assign rsp_rdata = rdata_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: vector table, corner sequences and random traffic against a transfer-level scoreboard
module tb_spi_arbiter;
    localparam int NREQ = 4, SS_SETUP = 2, SS_HOLD = 2, TIMEOUT = 64;

    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  req = '0, req_mlb = '0;
    logic [31:0] req_tdat = '0;
    logic [7:0]  req_cdiv = '0;
    logic [3:0]  gnt, ack, ss_n;
    logic [7:0]  rsp_rdata, m_tdat;
    logic [7:0]  m_rdata = 8'h00;
    logic        err, m_start, m_mlb;
    logic        m_done = 1'b0;
    logic [1:0]  m_cdiv;

    spi_arbiter #(.NREQ(NREQ), .SS_SETUP(SS_SETUP), .SS_HOLD(SS_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_tdat(req_tdat), .req_cdiv(req_cdiv), .req_mlb(req_mlb),
        .gnt(gnt), .ack(ack), .rsp_rdata(rsp_rdata), .err(err), .ss_n(ss_n), .m_start(m_start),
        .m_tdat(m_tdat), .m_cdiv(m_cdiv), .m_mlb(m_mlb), .m_done(m_done), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0, n = 0, starts = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, n);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (((r >> ((p + k) % NREQ)) & 4'b1) != 4'b0) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic int oh2i(input logic [3:0] v);
        int r = -1;
        for (int k = 0; k < NREQ; k++)
            if (((v >> k) & 4'b1) != 4'b0) r = k;
        return r;
    endfunction

    bit          act = 0, busy = 0, no_done = 0;
    int          g_cyc = 0, d_cyc = -1, a_cyc = -10, widx = 0, ptr_m = 0, lat = 0;
    logic [7:0]  exp_byte, exp_tdat, mbyte;
    logic        exp_err;
    logic [3:0]  oh, ess, eack;
    logic        p_rst = 1'b1;
    logic [3:0]  p_req = '0, p_mlb = '0;
    logic [31:0] p_tdat = '0;
    logic [7:0]  p_cdiv = '0;

    // Scoreboard on transfer events plus a loopback spi_master stand-in
    always @(negedge clk) begin
        int ac;
        n++;
        if (m_start) starts++;
        if (p_rst) begin
            act = 0; ptr_m = 0; busy = 0; m_done = 1'b0;
            chk("rst_gnt", gnt, 0);
            chk("rst_ack", ack, 0);
            chk("rst_ss_n", ss_n, 4'hF);
            chk("rst_m_start", m_start, 0);
            chk("rst_m_tdat", m_tdat, 8'hFF);
            chk("rst_m_cdiv", m_cdiv, 0);
            chk("rst_m_mlb", m_mlb, 0);
            chk("rst_rdata", rsp_rdata, 8'hFF);
            chk("rst_err", err, 0);
        end else begin
            if (!act && gnt != 4'b0) begin
                widx = pick(p_req, ptr_m);
                chk("grant_gap", n > a_cyc + 1, 1);
                if (widx < 0) chk("spurious_grant", gnt, 0);
                else begin
                    act = 1; g_cyc = n; d_cyc = -1;
                    oh = 4'(1 << widx);
                    exp_tdat = 8'(p_tdat >> (8 * widx));
                    exp_byte = exp_tdat; exp_err = 1'b0;
                    if (no_done) begin
                        d_cyc = n + SS_SETUP + TIMEOUT;
                        exp_byte = 8'hFF; exp_err = 1'b1;
                    end
                    chk("grant", gnt, oh);
                    chk("m_tdat_latch", m_tdat, exp_tdat);
                    chk("m_cdiv_latch", m_cdiv, 2'(p_cdiv >> (2 * widx)));
                    chk("m_mlb_latch", m_mlb, 1'(p_mlb >> widx));
                end
            end
            if (act) begin
                ac = (d_cyc < 0) ? -1 : d_cyc + 1 + SS_HOLD;
                ess = (n == ac) ? 4'hF : ~oh;
                eack = (n == ac) ? oh : 4'b0;
                chk("gnt_hold", gnt, oh);
                chk("ss_n", ss_n, ess);
                chk("m_start", m_start, n == g_cyc + SS_SETUP);
                chk("ack", ack, eack);
                if (n == d_cyc + 1) begin
                    chk("rdata_after_done", rsp_rdata, exp_byte);
                    chk("m_tdat_stable", m_tdat, exp_tdat);
                end
                if (n == ac) begin
                    chk("ack_rdata", rsp_rdata, exp_byte);
                    chk("ack_err", err, exp_err);
                    ptr_m = (widx + 1) % NREQ;
                    act = 0; a_cyc = n;
                end else if (n - g_cyc > 2000) begin
                    compared++; mismatched++;
                    $display("FAIL transfer_budget: no ack after %0d cycles, required one", n - g_cyc);
                    act = 0;
                end
            end else begin
                chk("idle_ack", ack, 0);
                chk("idle_ss_n", ss_n, 4'hF);
                chk("idle_m_start", m_start, 0);
            end
            if (m_start && !busy) begin
                busy = 1; lat = 8 * (m_cdiv + 1) + 2; m_done = 1'b0; mbyte = m_tdat;
            end else if (busy) begin
                lat--;
                if (lat == 0) begin
                    busy = 0;
                    if (!no_done) begin
                        m_done = 1'b1; m_rdata = mbyte;
                        if (act) d_cyc = n;
                    end
                end
            end
        end
        p_rst = rst; p_req = req; p_tdat = req_tdat; p_cdiv = req_cdiv; p_mlb = req_mlb;
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic wait_ack(input int budget, output int idx);
        idx = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (ack != 4'b0) begin idx = oh2i(ack); break; end
        end
        if (idx < 0) begin
            compared++; mismatched++;
            $display("FAIL ack_timeout: no ack within %0d cycles, required one", budget);
        end
        step;
    endtask

    task automatic wait_start(input int budget);
        bit seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            seen = m_start;
        end
        if (!seen) begin
            compared++; mismatched++;
            $display("FAIL start_timeout: no m_start within %0d cycles, required one", budget);
        end
        step;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] tdat;
        logic [7:0]  cdiv;
        logic [3:0]  mlb;
        int          idx;
        logic [7:0]  rd;
    } vec_t;

    initial begin
        vec_t vt[7];
        int   idx, s0;
        int   exp_rr[5];
        vt[0] = '{4'b1111, 32'h1A2B3C4D, 8'hE4, 4'b0101, 1, 8'h3C};
        vt[1] = '{4'b0001, 32'h55AA0F01, 8'h1B, 4'b1110, 0, 8'h01};
        vt[2] = '{4'b1001, 32'hC0FFEE11, 8'hC6, 4'b1000, 3, 8'hC0};
        vt[3] = '{4'b1010, 32'h12345678, 8'h08, 4'b0010, 1, 8'h56};
        vt[4] = '{4'b0110, 32'h9ABCDEF0, 8'h30, 4'b0100, 2, 8'hBC};
        vt[5] = '{4'b0100, 32'h00800000, 8'h00, 4'b0000, 2, 8'h80};
        vt[6] = '{4'b1000, 32'h7E000000, 8'h40, 4'b1111, 3, 8'h7E};
        exp_rr = '{0, 1, 2, 3, 0};

        repeat (3) step;
        rst = 1'b0;
        step;

        req_tdat = 32'h000000A5; req_mlb = 4'b0001; req_cdiv = '0; req = 4'b0001;
        s0 = starts;
        wait_ack(300, idx);
        chk("t1_ack_idx", idx, 0);
        chk("t1_rdata", rsp_rdata, 8'hA5);
        chk("t1_err", err, 0);
        chk("t1_start_pulses", starts - s0, 1);
        req = '0;

        foreach (vt[i]) begin
            req_tdat = vt[i].tdat; req_cdiv = vt[i].cdiv; req_mlb = vt[i].mlb; req = vt[i].req;
            wait_ack(400, idx);
            chk($sformatf("vec%0d_idx", i), idx, vt[i].idx);
            chk($sformatf("vec%0d_rdata", i), rsp_rdata, vt[i].rd);
        end

        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(400, idx);
            chk($sformatf("rr%0d_idx", i), idx, exp_rr[i]);
        end
        req = '0;

        req_tdat = 32'h003C0000; req_cdiv = '0; req = 4'b0100;
        wait_start(50);
        repeat (3) step;
        req_tdat = 32'h00C30000;
        wait_ack(300, idx);
        chk("tchg_idx", idx, 2);
        chk("tchg_rdata", rsp_rdata, 8'h3C);
        req = '0;

        req_tdat = 32'h00005A00; req = 4'b0010;
        wait_start(50);
        repeat (4) step;
        rst = 1'b1; req = '0;
        step;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_gnt", gnt, 0);
        chk("rstw_ss_n", ss_n, 4'hF);
        chk("rstw_m_start", m_start, 0);
        chk("rstw_ack", ack, 0);
        step;
        repeat (20) step;
        req = 4'b0010;
        wait_ack(300, idx);
        chk("rstw_new_idx", idx, 1);
        chk("rstw_new_rdata", rsp_rdata, 8'h5A);
        req = '0;

        req_tdat = 32'h99000077; req = 4'b1000;
        wait_start(50);
        req = 4'b1001;
        repeat (3) step;
        req = 4'b1000;
        wait_ack(300, idx);
        chk("wd_first_idx", idx, 3);
        wait_ack(300, idx);
        chk("wd_second_idx", idx, 3);
        chk("wd_rdata", rsp_rdata, 8'h99);
        req = '0;
        repeat (10) step;

`ifdef SPI_ARB_TIMEOUT_EN
        no_done = 1; req_tdat = 32'h00000011; req = 4'b0001;
        wait_ack(300, idx);
        chk("to_idx", idx, 0);
        chk("to_err", err, 1);
        chk("to_rdata", rsp_rdata, 8'hFF);
        no_done = 0; req = '0;
        repeat (5) step;
`endif

        for (int it = 0; it < 40; it++) begin
            req_tdat = $urandom; req_cdiv = 8'($urandom); req_mlb = 4'($urandom); req = 4'($urandom);
            if (req == 4'b0) repeat (4) step;
            else wait_ack(400, idx);
        end
        req = '0;
        repeat (50) step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
